// File: rtl/mul_operand_join_pkg.sv
// ---------------------------------------------------------------------------
// mul_operand_join_pkg
//
// Purpose : Shared constants for the multiplier operand path. Fixes the
//           layout of the packed request word so that the operand producer
//           and the multiplier agree on where each operand lives.
//
// Layout  : the request word is OPND_SLOTS operand slots of p_width bits.
//           Operand A occupies slot OPND_A_SLOT (least significant), and
//           operand B occupies slot OPND_B_SLOT (most significant), i.e.
//           req_msg = {B, A}.
// ---------------------------------------------------------------------------
package mul_operand_join_pkg;

    localparam int unsigned OPND_SLOTS  = 2;
    localparam int unsigned OPND_A_SLOT = 0;
    localparam int unsigned OPND_B_SLOT = 1;

endpackage

// File: rtl/mul_operand_queue.sv
// ---------------------------------------------------------------------------
// mul_operand_queue
//
// Purpose : Small circular FIFO holding one operand stream. The depth need
//           not be a power of two, so pointers wrap on an explicit compare.
//
// Ports   :
//   clk      in   clock, state updates on posedge
//   reset    in   asynchronous active-low reset (asserted when 0)
//   enq_val  in   enqueue valid
//   enq_rdy  out  enqueue ready (queue not full and not in reset)
//   enq_msg  in   enqueue data
//   deq_en   in   pop the head entry this cycle
//   deq_msg  out  head entry
//   count    out  current occupancy
// ---------------------------------------------------------------------------
module mul_operand_queue #(
    parameter  int p_width     = 4,
    parameter  int p_depth     = 2,
    localparam int p_cnt_width = $clog2(p_depth + 1),
    localparam int p_ptr_width = $clog2(p_depth)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val,
    output logic                   enq_rdy,
    input  logic [p_width-1:0]     enq_msg,
    input  logic                   deq_en,
    output logic [p_width-1:0]     deq_msg,
    output logic [p_cnt_width-1:0] count
);

    localparam logic [p_cnt_width-1:0] FULL_COUNT = p_cnt_width'(p_depth);
    localparam logic [p_ptr_width-1:0] LAST_PTR   = p_ptr_width'(p_depth - 1);

    logic [p_width-1:0]     storage [p_depth];
    logic [p_ptr_width-1:0] wr_ptr;
    logic [p_ptr_width-1:0] rd_ptr;
    logic                   enq_go;
    logic                   deq_go;

    // Ready looks only at the stored count, so a full queue refuses a new
    // operand even in a cycle where it is also being popped.
    assign enq_rdy = (count != FULL_COUNT) & reset;
    assign enq_go  = enq_val & enq_rdy;
    // An empty queue never pops, even if the caller asks.
    assign deq_go  = deq_en & (count != '0);
    assign deq_msg = storage[rd_ptr];

    // Pointers, storage and occupancy. Simultaneous push and pop advance
    // both pointers and leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < p_depth; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (enq_go) begin
                storage[wr_ptr] <= enq_msg;
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + p_ptr_width'(1);
            end
            if (deq_go) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + p_ptr_width'(1);
            end
            unique case ({enq_go, deq_go})
                2'b10:   count <= count + p_cnt_width'(1);
                2'b01:   count <= count - p_cnt_width'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_operand_join.sv
// ---------------------------------------------------------------------------
// mul_operand_join
//
// Purpose : Front end of the multiplier. Buffers operand A and operand B in
//           independent queues and offers a packed {B, A} request once both
//           queues hold an entry. Both queues pop together on acceptance.
//
// Ports   :
//   clk       in   clock, state updates on posedge
//   reset     in   asynchronous active-low reset (asserted when 0)
//   a_val     in   operand A valid
//   a_rdy     out  operand A ready
//   a_msg     in   operand A data
//   b_val     in   operand B valid
//   b_rdy     out  operand B ready
//   b_msg     in   operand B data
//   resp_val  out  packed pair valid (to multiplier req_val)
//   resp_rdy  in   downstream ready (from multiplier req_rdy)
//   resp_msg  out  packed pair {B, A} (to multiplier req_msg)
//   a_count   out  A queue occupancy
//   b_count   out  B queue occupancy
// ---------------------------------------------------------------------------
module mul_operand_join
    import mul_operand_join_pkg::*;
#(
    parameter  int p_width     = 4,
    parameter  int p_depth     = 2,
    localparam int p_cnt_width = $clog2(p_depth + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            a_val,
    output logic                            a_rdy,
    input  logic [p_width-1:0]              a_msg,
    input  logic                            b_val,
    output logic                            b_rdy,
    input  logic [p_width-1:0]              b_msg,
    output logic                            resp_val,
    input  logic                            resp_rdy,
    output logic [OPND_SLOTS*p_width-1:0]   resp_msg,
    output logic [p_cnt_width-1:0]          a_count,
    output logic [p_cnt_width-1:0]          b_count
);

    logic [p_width-1:0] a_head;
    logic [p_width-1:0] b_head;
    logic               resp_go;

    mul_operand_queue #(
        .p_width (p_width),
        .p_depth (p_depth)
    ) a_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (a_val),
        .enq_rdy (a_rdy),
        .enq_msg (a_msg),
        .deq_en  (resp_go),
        .deq_msg (a_head),
        .count   (a_count)
    );

    mul_operand_queue #(
        .p_width (p_width),
        .p_depth (p_depth)
    ) b_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (b_val),
        .enq_rdy (b_rdy),
        .enq_msg (b_msg),
        .deq_en  (resp_go),
        .deq_msg (b_head),
        .count   (b_count)
    );

    // Valid comes from stored occupancy only, which keeps a full register
    // stage between operand inputs and the multiplier request.
    assign resp_val = (a_count != '0) && (b_count != '0);
    assign resp_go  = resp_val & resp_rdy;

    // Heads are placed into their slots of the shared request layout.
    always_comb begin
        resp_msg = '0;
        resp_msg[OPND_A_SLOT*p_width +: p_width] = a_head;
        resp_msg[OPND_B_SLOT*p_width +: p_width] = b_head;
    end

endmodule

// File: doc/mul_operand_join.md
Name: mul_operand_join

Overview:
- Upstream stage of the multiplier operator. It joins two independent operand streams, A and B, into the packed 2*p_width request that the multiplier consumes.
- Each operand channel has its own p_depth-entry queue, so A and B may arrive in different cycles and at different rates.
- A packed message is offered downstream only when both queues are non-empty.
- The output connects directly to the multiplier's req_val/req_rdy/req_msg.

Parameters:
- p_width, 4: bitwidth of one operand.
- p_depth, 2: entries per operand queue. Must be >= 2; need not be a power of two.
- p_cnt_width, $clog2(p_depth+1): occupancy counter width. Derived; never set externally.
- p_ptr_width, $clog2(p_depth): queue pointer width. Derived; never set externally.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- a_val  input  1  operand A valid.
- a_rdy  output  1  operand A ready.
- a_msg  input  p_width  operand A data.
- b_val  input  1  operand B valid.
- b_rdy  output  1  operand B ready.
- b_msg  input  p_width  operand B data.
- resp_val  output  1  packed pair valid (to multiplier req_val).
- resp_rdy  input  1  downstream ready (from multiplier req_rdy).
- resp_msg  output  2*p_width  packed pair (to multiplier req_msg).
- a_count  output  p_cnt_width  current A queue occupancy.
- b_count  output  p_cnt_width  current B queue occupancy.

Behaviour:
- Reset (reset==0, asynchronous): all counts, pointers and storage entries clear to 0.
  - While reset is asserted: a_rdy=b_rdy=0, resp_val=0, resp_msg=0, a_count=b_count=0.
  - Reset mid-operation discards all queued operands; no partial pair survives.
- Handshake events: a_go=a_val&a_rdy; b_go=b_val&b_rdy; resp_go=resp_val&resp_rdy.
- Ready: a_rdy=(a_count!=p_depth)&reset, and likewise for b_rdy.
  - Ready does not depend combinationally on resp_rdy: a full queue refuses enqueue even in a cycle where it dequeues.
- Valid: resp_val=(a_count!=0)&(b_count!=0). It is combinational from state only; no dependency on a_val or b_val.
- Data packing: resp_msg={B head, A head}.
  - A occupies bits [p_width-1:0]; B occupies bits [2*p_width-1:p_width].
  - This matches the multiplier operand layout. No arithmetic, no truncation.
- Dequeue: resp_go pops one entry from both queues in the same cycle; the two queues never pop independently.
- Enqueue: on a_go, a_msg is written at the A write pointer, and that pointer advances. B behaves identically and independently.
- Same-cycle enqueue and dequeue on one queue: both pointers advance and the count is unchanged.
- Pointer wrap: a pointer equal to p_depth-1 advances to 0 (explicit compare, since p_depth may be a non-power-of-two).
- Latency: 1 cycle minimum. An operand pair accepted on edge N gives resp_val=1 after edge N.
  - No combinational bypass from input to output.
- Throughput: 1 pair per cycle sustained when both inputs stream and resp_rdy=1, for p_depth>=2.
- Backpressure: with resp_rdy=0, each queue fills to p_depth, then its rdy drops.
  - Head data and resp_msg are held stable while resp_val=1 and no resp_go occurs.
- Skew: any imbalance up to p_depth is absorbed. The leading queue stalls when full, and the lagging channel still accepts.
- Counts: occupancies never exceed p_depth and never underflow. Dequeue is only possible when both counts are non-zero.

Decomposition:
- Shared package: no new typedefs. The operand packing order (A low, B high) is one documented constant/function in the existing mul package, so producer and multiplier agree.
- One sub-module, mul_operand_queue, instantiated twice (A and B):
  - Parameters: p_width, p_depth.
  - Ports: clk, reset, enq_val, enq_rdy, enq_msg, deq_en, deq_msg, count.
  - Contents: pointers, storage and counter.
- The top level holds only the join logic and the packing.

Test Plan:
- Reset: hold reset=0 while driving a_val=b_val=1 -> a_rdy=b_rdy=0, resp_val=0, counts 0. After release, a_rdy=b_rdy=1.
- Basic join: p_width=4. Send a_msg=4'h3, b_msg=4'h5 on the same edge with resp_rdy=1 -> next cycle resp_val=1 and resp_msg=8'h53. After resp_go, counts return to 0.
- Skew: send A=1,2 on two cycles with no B -> resp_val=0, a_count=2, a_rdy=0. Then send B=7,9 -> outputs 8'h71 then 8'h92, in order.
- Backpressure/full: resp_rdy=0, push 3 pairs with p_depth=2 -> only 2 accepted per side and rdy=0 while full. resp_msg stays stable. Releasing resp_rdy drains both pairs in order.
- Streaming: resp_rdy=1 with 20 random pairs back-to-back -> one resp_go per cycle after the first, exact order preserved, counts never exceed 1. Repeat with p_depth=3 to exercise non-power-of-two wrap.
- Reset mid-operation: with 2 entries queued, pulse reset low -> counts 0, resp_val=0 immediately (asynchronously). After release, no stale data is emitted.
